// File: rtl/song_player.sv
`default_nettype none
// ============================================================================
//  Module      : song_player
//  Description : Autoplay sequencer stepping through a loadable 32-entry song
//                table, driving the organ tone generator note by note.
//  Revision    : 1.0  initial release
// ============================================================================
module song_player #(
    parameter int TICK_DIV = 250000,
    parameter int GAP_CYC  = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_sel,
    input  logic       play_btn,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [2:0] value_play,
    output logic [1:0] tone_play,
    output logic       state,
    output logic [4:0] note_idx
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_NOTE  = 3'd2,
        S_GAP   = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    state_t          fsm_q, resume_q, run_d;
    logic [7:0]      mem_q [32];
    logic            play_q;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      beat_q, beat_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [4:0]      note_idx_q, idx_d;
    logic [2:0]      val_q, dur_q;
    logic [1:0]      tone_q;
    logic [2:0]      value_play_q;
    logic [1:0]      tone_play_q;
    logic            state_q;
    logic [7:0]      w_entry;
    logic            w_play_edge;

    assign w_entry     = mem_q[note_idx_q];
    assign w_play_edge = play_btn & ~play_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 32; k++) begin
                mem_q[k] <= 8'h00;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Undisturbed progression of NOTE/GAP; pause only overrides the state.
    always_comb begin
        run_d  = fsm_q;
        tick_d = tick_q;
        beat_d = beat_q;
        gap_d  = gap_q;
        idx_d  = note_idx_q;
        case (fsm_q)
            S_NOTE: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (beat_q == dur_q) begin
                        beat_d = 3'd0;
                        run_d  = S_GAP;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    idx_d = note_idx_q + 5'd1;
                    run_d = S_FETCH;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q        <= S_IDLE;
            resume_q     <= S_IDLE;
            play_q       <= 1'b0;
            tick_q       <= '0;
            beat_q       <= 3'd0;
            gap_q        <= '0;
            note_idx_q   <= 5'd0;
            val_q        <= 3'd0;
            tone_q       <= 2'd0;
            dur_q        <= 3'd0;
            value_play_q <= 3'd0;
            tone_play_q  <= 2'd0;
            state_q      <= 1'b0;
        end else begin
            play_q <= play_btn;
            if (!mode_sel) begin
                fsm_q        <= S_IDLE;
                tick_q       <= '0;
                beat_q       <= 3'd0;
                gap_q        <= '0;
                note_idx_q   <= 5'd0;
                value_play_q <= 3'd0;
                tone_play_q  <= 2'd0;
                state_q      <= 1'b0;
            end else begin
                case (fsm_q)
                    S_IDLE: begin
                        note_idx_q   <= 5'd0;
                        value_play_q <= 3'd0;
                        tone_play_q  <= 2'd0;
                        state_q      <= 1'b0;
                        if (w_play_edge) begin
                            fsm_q   <= S_FETCH;
                            state_q <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        if (w_entry != 8'h00) begin
                            val_q        <= w_entry[7:5];
                            tone_q       <= w_entry[4:3];
                            dur_q        <= w_entry[2:0];
                            value_play_q <= w_entry[7:5];
                            tone_play_q  <= w_entry[4:3];
                            fsm_q        <= S_NOTE;
                        end else if (note_idx_q != 5'd0) begin
                            note_idx_q <= 5'd0;
                        end else begin
                            fsm_q        <= S_IDLE;
                            value_play_q <= 3'd0;
                            tone_play_q  <= 2'd0;
                            state_q      <= 1'b0;
                        end
                    end
                    S_NOTE, S_GAP: begin
                        tick_q     <= tick_d;
                        beat_q     <= beat_d;
                        gap_q      <= gap_d;
                        note_idx_q <= idx_d;
                        if (w_play_edge) begin
                            fsm_q        <= S_PAUSE;
                            resume_q     <= run_d;
                            value_play_q <= 3'd0;
                        end else begin
                            fsm_q        <= run_d;
                            value_play_q <= (run_d == S_NOTE) ? val_q : 3'd0;
                        end
                    end
                    S_PAUSE: begin
                        if (w_play_edge) begin
                            fsm_q        <= resume_q;
                            value_play_q <= (resume_q == S_NOTE) ? val_q : 3'd0;
                        end
                    end
                    default: begin
                        fsm_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign value_play = value_play_q;
    assign tone_play  = tone_play_q;
    assign state      = state_q;
    assign note_idx   = note_idx_q;

    logic w_unused;
    assign w_unused = ^tone_q;

endmodule
`default_nettype wire

// File: doc/song_player.md
# song_player

Autoplay sequencer for the electronic organ. Holds a loadable 32-entry song table and steps through it note by note. It drives the `value_play`, `tone_play` and `state` inputs of the square-wave tone generator, which then selects these over the keyboard inputs. Note length is a multiple of a programmable beat tick, and a short silent gap between notes keeps repeated notes audibly separate.

## Interface
- `TICK_DIV`, default 250000: clock cycles per beat (0.125 s at the 2 MHz organ clock); must be ≥ 1.
- `GAP_CYC`, default 20000: silent cycles after each note; must be ≥ 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset: synchronous, active-low.
- `mode_sel`  in  1  1 = autoplay selected; 0 forces IDLE.
- `play_btn`  in  1  play/pause button, already debounced, level input.
- `wr_en`  in  1  song table write strobe.
- `wr_addr`  in  5  table address.
- `wr_data`  in  8  entry: [7:5] value, [4:3] tone, [2:0] dur.
- `value_play`  out  3  note to the tone generator; 0 means silence.
- `tone_play`  out  2  octave to the tone generator.
- `state`  out  1  1 while a song is active; selects the autoplay source.
- `note_idx`  out  5  table index of the current entry.

## Operation
- **Entry format.**
  - A note lasts (dur+1) beats.
  - value=0 with a nonzero byte is a rest (e.g. 0x08).
  - Byte 0x00 is the end marker.
- **Table.**
  - 32×8 registers, all cleared to 0x00 on reset.
  - Write is `mem[wr_addr] <= wr_data` when `wr_en`=1, in any state.
  - Reads are combinational.
  - A write to the entry currently sounding does not change the latched note. The change takes effect at the next FETCH.
- **Play edge.** `play_q` is a registered `play_btn`; `play_edge = play_btn & ~play_q`.
- **IDLE.**
  - Outputs: `value_play`=0, `tone_play`=0, `state`=0, `note_idx`=0.
  - On `play_edge` with `mode_sel`=1, go to FETCH.
- **FETCH (1 cycle).**
  - `value_play`=0 and `state`=1.
  - Entry = `mem[note_idx]`.
  - If entry ≠ 0x00: latch value, tone and dur, then go to NOTE.
  - If entry = 0x00 and `note_idx`≠0: set `note_idx`←0 and stay in FETCH (song loops).
  - If entry = 0x00 and `note_idx`=0 (empty song): go to IDLE.
- **NOTE.**
  - `value_play` and `tone_play` show the latched fields.
  - A tick counter counts 0..TICK_DIV-1 and a beat counter counts 0..dur.
  - At the last cycle of the last beat, go to GAP.
- **GAP.**
  - `value_play`=0; `tone_play` is held.
  - Counts GAP_CYC cycles.
  - On its last cycle, set `note_idx`←`note_idx`+1 (31 wraps to 0) and go to FETCH.
- **PAUSE.**
  - Entered on `play_edge` from NOTE or GAP; all counters freeze.
  - `value_play`=0; `state`=1; `note_idx` is held.
  - On `play_edge`, return to the saved state (NOTE or GAP) with counters continuing where they stopped.
  - `play_edge` in FETCH is ignored.
- **Mode drop.** `mode_sel`=0 in any state: next cycle go to IDLE, with `note_idx`=0 and all outputs at their IDLE values. `mode_sel` has priority over `play_edge`.
- **Output registration.** All outputs are registered; no combinational paths from inputs to outputs.

## Timing
- **Reset.** `rst`=0 sampled at a rising edge produces, next cycle:
  - FSM in IDLE;
  - `value_play`=0, `tone_play`=0, `state`=0, `note_idx`=0;
  - counters=0, `play_q`=0, table cleared.
  - Reset mid-song aborts immediately.
- **Start latency.** `play_btn` is first sampled high at edge N. FETCH is at N+1, and `value_play` is valid from N+2.
- **Note period.** Each note holds `value_play` ≠ 0 for exactly (dur+1)·TICK_DIV cycles, followed by GAP_CYC + 1 silent cycles (GAP then FETCH). Each loop-wrap FETCH adds one further silent cycle.
- **Pause latency.** Output goes silent one cycle after the edge is sampled. On resume, the remaining NOTE cycles equal those left at pause.
- **Held button.** Holding `play_btn` high produces exactly one edge.

## Test plan
Use TICK_DIV=4 and GAP_CYC=2 in all scenarios.
1. **Basic play.** Load 0x22 (value 1, tone 0, dur 2), 0x5B, 0x00; `mode_sel`=1; pulse `play_btn` → `value_play`=1 for 12 cycles, 0 for 3 cycles, 2 for 16 cycles, 0 for 4 cycles (GAP + two FETCH cycles on the wrap), then 1 again with `note_idx`=0. `state`=1 throughout.
2. **Reset values and empty table.** Reset, set `mode_sel`=1, pulse play → FETCH for one cycle, then IDLE with `state`=0 and `value_play`=0.
3. **Pause mid-note.** Pause 5 cycles into a 12-cycle note and hold 20 cycles → `value_play`=0, `state`=1, `note_idx` unchanged. Resume → note sounds for exactly 7 more cycles.
4. **Index wrap and rest.** Fill all 32 entries with 0x08 (rest) except entry 31 = 0xE0 → `note_idx` goes 31→0 with no end marker, and `value_play`=7 only while `note_idx`=31.
5. **Mode drop and reset.** `mode_sel`→0 mid-NOTE → IDLE next cycle with all outputs 0. Separately, `rst`=0 mid-GAP → IDLE and table reads 0x00.
6. **Write to current entry.** Write entry 0 with 0xFF while entry 0 is sounding → current note unchanged; the next pass plays value 7, tone 3 for 8 beats.
